spi_reg_burst: RTL and testbench

//  SPI slave to register-bank bridge. Supports SPI modes 0-3, a REG_W-bit data word and multi-word

---
 rtl/spi_reg_burst.sv | 172 +++++++++++++++++
 tb/tb_spi_reg_burst.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_burst.sv
// SPI slave to register-bank bridge: oversampled SPI pins, command byte then
// auto-incrementing bursts of REG_W-bit words, all in the clk domain.
module spi_reg_burst #(
  parameter int ADDR_W      = 7,
  parameter int REG_W       = 8,
  parameter int AUTO_INC    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic [1:0]        mode,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [REG_W-1:0]  reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [REG_W-1:0]  reg_rdata,
  input  logic [7:0]        status,
  output logic              busy,
  output logic              frame_abort
);

  localparam int CNT_W = $clog2(REG_W) + 1;

  typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_reg, cs_sync_reg, mosi_sync_reg;
  logic                   sclk_prev_reg, cs_prev_reg;

  state_t                 state_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [REG_W-2:0]       shift_reg;
  logic [REG_W-1:0]       tx_reg;
  logic                   sampled_reg;
  logic [ADDR_W-1:0]      addr_reg;
  logic [REG_W-1:0]       wdata_reg;
  logic                   we_reg, re_reg, abort_reg;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, sample_on_rise, sample_edge, change_edge;
  logic cs_fall, cs_rise;
  logic [REG_W-1:0] word_in;
  logic [CNT_W-1:0] last_cnt;
  logic word_done;

  // Synchronisers reset to the idle bus levels so reset never fakes an SCLK edge.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      sclk_sync_reg <= {SYNC_STAGES{mode[1]}};
      cs_sync_reg   <= '1;
      mosi_sync_reg <= '0;
      sclk_prev_reg <= mode[1];
      cs_prev_reg   <= 1'b1;
    end else if (ena) begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], spi_clk};
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_reg <= sclk_s;
      cs_prev_reg   <= cs_s;
    end
  end

  assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
  assign cs_s   = cs_sync_reg[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

  assign sclk_rise      = sclk_s & ~sclk_prev_reg & ~cs_s;
  assign sclk_fall      = ~sclk_s & sclk_prev_reg & ~cs_s;
  // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
  assign sample_on_rise = (mode[1] == mode[0]);
  assign sample_edge    = sample_on_rise ? sclk_rise : sclk_fall;
  assign change_edge    = sample_on_rise ? sclk_fall : sclk_rise;
  assign cs_fall        = cs_prev_reg & ~cs_s;
  assign cs_rise        = ~cs_prev_reg & cs_s;

  assign word_in   = {shift_reg, mosi_s};
  assign last_cnt  = (state_reg == CMD) ? CNT_W'(7) : CNT_W'(REG_W - 1);
  assign word_done = (cnt_reg == last_cnt);

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      shift_reg   <= '0;
      tx_reg      <= '0;
      sampled_reg <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      we_reg      <= 1'b0;
      re_reg      <= 1'b0;
      abort_reg   <= 1'b0;
    end else if (ena) begin
      we_reg    <= 1'b0;
      re_reg    <= 1'b0;
      abort_reg <= 1'b0;
      if (AUTO_INC != 0 && we_reg)
        addr_reg <= addr_reg + 1'b1;

      if (cs_rise) begin
        // End of frame wins over any word completing in the same cycle.
        state_reg <= IDLE;
        cnt_reg   <= '0;
        abort_reg <= (cnt_reg != '0);
      end else begin
        if (sample_edge && state_reg != IDLE) begin
          shift_reg <= word_in[REG_W-2:0];
          cnt_reg   <= word_done ? '0 : cnt_reg + 1'b1;
        end
        case (state_reg)
          IDLE: begin
            if (cs_fall) begin
              state_reg <= CMD;
              cnt_reg   <= '0;
            end
          end
          CMD: begin
            if (sample_edge && word_done) begin
              addr_reg <= word_in[ADDR_W-1:0];
              if (word_in[7]) begin
                state_reg <= WRITE;
              end else begin
                state_reg <= READ;
                re_reg    <= 1'b1;
              end
            end
          end
          WRITE: begin
            if (sample_edge && word_done) begin
              we_reg    <= 1'b1;
              wdata_reg <= word_in;
            end
          end
          READ: begin
            if (sample_edge && word_done) begin
              re_reg <= 1'b1;
              if (AUTO_INC != 0)
                addr_reg <= addr_reg + 1'b1;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end

      // A change edge before the first sample after a load keeps the MSB on MISO.
      if (state_reg == IDLE && cs_fall) begin
        tx_reg      <= REG_W'(status) << (REG_W - 8);
        sampled_reg <= 1'b0;
      end else if (re_reg) begin
        tx_reg      <= reg_rdata;
        sampled_reg <= 1'b0;
      end else begin
        if (sample_edge && state_reg != IDLE)
          sampled_reg <= 1'b1;
        if (change_edge && sampled_reg)
          tx_reg <= {tx_reg[REG_W-2:0], 1'b0};
      end
    end
  end

  assign spi_miso    = tx_reg[REG_W-1];
  assign reg_addr    = addr_reg;
  assign reg_wdata   = wdata_reg;
  assign reg_we      = we_reg;
  assign reg_re      = re_reg;
  assign busy        = (state_reg != IDLE);
  assign frame_abort = abort_reg;

endmodule

// File: tb/tb_spi_reg_burst.sv
// Bench for spi_reg_burst: three instances (8-bit auto-inc, 8-bit fixed address,
// 16-bit) driven by a bit-banged SPI master; strobes checked by a scoreboard monitor.
`timescale 1ns/1ps
module tb_spi_reg_burst;

  localparam int HALF = 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstb, ena, sclk, mosi;
  logic [1:0] mode;
  logic [2:0] cs_n;
  logic [7:0] status;
  logic [31:0] bank [128];

  logic       miso0, miso1, miso2, we0, we1, we2, re0, re1, re2;
  logic       busy0, busy1, busy2, abort0, abort1, abort2;
  logic [6:0] addr0, addr1, addr2;
  logic [7:0] wdata0, wdata1, rdata0, rdata1;
  logic [15:0] wdata2, rdata2;

  assign rdata0 = bank[addr0][7:0];
  assign rdata1 = bank[addr1][7:0];
  assign rdata2 = bank[addr2][15:0];

  spi_reg_burst #(.ADDR_W(7), .REG_W(8), .AUTO_INC(1), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .rstb(rstb), .ena(ena), .mode(mode), .spi_clk(sclk), .spi_cs_n(cs_n[0]),
    .spi_mosi(mosi), .spi_miso(miso0), .reg_addr(addr0), .reg_wdata(wdata0), .reg_we(we0),
    .reg_re(re0), .reg_rdata(rdata0), .status(status), .busy(busy0), .frame_abort(abort0));

  spi_reg_burst #(.ADDR_W(7), .REG_W(8), .AUTO_INC(0), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rstb(rstb), .ena(ena), .mode(mode), .spi_clk(sclk), .spi_cs_n(cs_n[1]),
    .spi_mosi(mosi), .spi_miso(miso1), .reg_addr(addr1), .reg_wdata(wdata1), .reg_we(we1),
    .reg_re(re1), .reg_rdata(rdata1), .status(status), .busy(busy1), .frame_abort(abort1));

  spi_reg_burst #(.ADDR_W(7), .REG_W(16), .AUTO_INC(1), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .rstb(rstb), .ena(ena), .mode(mode), .spi_clk(sclk), .spi_cs_n(cs_n[2]),
    .spi_mosi(mosi), .spi_miso(miso2), .reg_addr(addr2), .reg_wdata(wdata2), .reg_we(we2),
    .reg_re(re2), .reg_rdata(rdata2), .status(status), .busy(busy2), .frame_abort(abort2));

  logic [2:0]  we_v, re_v, abort_v, miso_v;
  logic [6:0]  addr_v [3];
  logic [31:0] wdata_v [3];
  assign we_v    = {we2, we1, we0};
  assign re_v    = {re2, re1, re0};
  assign abort_v = {abort2, abort1, abort0};
  assign miso_v  = {miso2, miso1, miso0};
  assign addr_v[0] = addr0;
  assign addr_v[1] = addr1;
  assign addr_v[2] = addr2;
  assign wdata_v[0] = {24'h0, wdata0};
  assign wdata_v[1] = {24'h0, wdata1};
  assign wdata_v[2] = {16'h0, wdata2};

  typedef struct packed {
    logic        we;
    logic [6:0]  addr;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q [3][$];
  ev_t mon_e;
  int  n_checks = 0;
  int  n_pass = 0;
  int  abort_cnt [3] = '{0, 0, 0};

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
      $display("ok   %s value=%0h", name, act);
    end else begin
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic ev_t mk(input logic we, input logic [6:0] addr, input logic [31:0] data);
    ev_t e;
    e.we = we;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

  // Scoreboard monitor: every strobe must match the next expected event.
  always @(negedge clk) begin
    if (rstb) begin
      for (int i = 0; i < 3; i++) begin
        if (abort_v[i]) abort_cnt[i]++;
        if (we_v[i] || re_v[i]) begin
          if (exp_q[i].size() == 0) begin
            n_checks++;
            $display("FAIL strobe_dut%0d actual we=%0b re=%0b addr=%0h required no strobe",
                     i, we_v[i], re_v[i], addr_v[i]);
          end else begin
            mon_e = exp_q[i].pop_front();
            chk($sformatf("strobe_dut%0d", i),
                {22'h0, re_v[i], we_v[i], addr_v[i], (we_v[i] ? wdata_v[i] : 32'h0)},
                {22'h0, ~mon_e.we, mon_e.we, mon_e.addr, (mon_e.we ? mon_e.data : 32'h0)});
          end
        end
      end
    end
  end

  task automatic frame_start(input int sel, input logic [1:0] m);
    @(negedge clk);
    mode = m;
    sclk = m[1];
    #200;
    cs_n[sel] = 1'b0;
    #100;
  endtask

  task automatic frame_end(input int sel);
    #100;
    cs_n[sel] = 1'b1;
    #200;
  endtask

  task automatic xfer(input int sel, input int nbits, input logic [31:0] data,
                      output logic [31:0] rx);
    rx = '0;
    for (int b = nbits - 1; b >= 0; b--) begin
      if (!mode[0]) begin
        mosi = data[b];
        #HALF;
        sclk = ~mode[1];
        rx = {rx[30:0], miso_v[sel]};
        #HALF;
        sclk = mode[1];
      end else begin
        sclk = ~mode[1];
        mosi = data[b];
        #HALF;
        sclk = mode[1];
        rx = {rx[30:0], miso_v[sel]};
        #HALF;
      end
    end
  endtask

  logic [31:0] rx;
  int a0;

  initial begin
    for (int i = 0; i < 128; i++) bank[i] = 32'h0;
    bank[2] = 32'h5E;
    bank[5] = 32'hA5;
    bank[6] = 32'h3C;
    bank[7] = 32'h99;
    status = 8'hC3;
    rstb = 1'b0; ena = 1'b1; mode = 2'b00; sclk = 1'b0; mosi = 1'b0; cs_n = 3'b111;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy0, we0, re0, abort0, miso0, addr0, wdata0}, 64'h0);
    rstb = 1'b1;
    repeat (5) @(negedge clk);

    // 1: mode 0 single write
    exp_q[0].push_back(mk(1'b1, 7'h03, 32'h5A));
    a0 = abort_cnt[0];
    frame_start(0, 2'b00);
    xfer(0, 8, 32'h83, rx);
    chk("t1_miso_status", rx, 64'hC3);
    chk("t1_busy_in_frame", busy0, 1);
    xfer(0, 8, 32'h5A, rx);
    frame_end(0);
    chk("t1_no_abort", abort_cnt[0] - a0, 0);
    chk("t1_busy_after", busy0, 0);

    // 2: mode 3 burst write with address wrap
    exp_q[0].push_back(mk(1'b1, 7'h7E, 32'h11));
    exp_q[0].push_back(mk(1'b1, 7'h7F, 32'h22));
    exp_q[0].push_back(mk(1'b1, 7'h00, 32'h33));
    frame_start(0, 2'b11);
    xfer(0, 8, 32'hFE, rx);
    chk("t2_miso_status", rx, 64'hC3);
    xfer(0, 8, 32'h11, rx);
    xfer(0, 8, 32'h22, rx);
    xfer(0, 8, 32'h33, rx);
    frame_end(0);
    chk("t2_addr_after", addr0, 7'h01);

    // 3: mode 1 burst read with prefetch
    exp_q[0].push_back(mk(1'b0, 7'h05, 32'h0));
    exp_q[0].push_back(mk(1'b0, 7'h06, 32'h0));
    exp_q[0].push_back(mk(1'b0, 7'h07, 32'h0));
    frame_start(0, 2'b01);
    xfer(0, 8, 32'h05, rx);
    chk("t3_miso_status", rx, 64'hC3);
    xfer(0, 8, 32'h00, rx);
    chk("t3_miso_word0", rx, 64'hA5);
    xfer(0, 8, 32'h00, rx);
    chk("t3_miso_word1", rx, 64'h3C);
    frame_end(0);
    chk("t3_addr_after", addr0, 7'h07);

    // 4: mode 2, address held
    exp_q[1].push_back(mk(1'b0, 7'h02, 32'h0));
    exp_q[1].push_back(mk(1'b0, 7'h02, 32'h0));
    exp_q[1].push_back(mk(1'b0, 7'h02, 32'h0));
    frame_start(1, 2'b10);
    xfer(1, 8, 32'h02, rx);
    chk("t4_miso_status", rx, 64'hC3);
    xfer(1, 8, 32'h00, rx);
    chk("t4_miso_word0", rx, 64'h5E);
    xfer(1, 8, 32'h00, rx);
    chk("t4_miso_word1", rx, 64'h5E);
    frame_end(1);
    chk("t4_addr_after", addr1, 7'h02);

    // 5: partial word aborts
    a0 = abort_cnt[0];
    frame_start(0, 2'b00);
    xfer(0, 8, 32'h84, rx);
    xfer(0, 4, 32'hA, rx);
    chk("t5_busy_in_frame", busy0, 1);
    frame_end(0);
    chk("t5_abort_pulses", abort_cnt[0] - a0, 1);
    chk("t5_busy_after", busy0, 0);

    // 6: reset in the middle of a data word
    frame_start(0, 2'b00);
    xfer(0, 8, 32'h82, rx);
    xfer(0, 3, 32'h5, rx);
    @(negedge clk);
    rstb = 1'b0;
    @(negedge clk);
    chk("t6_reset_outputs", {busy0, we0, re0, abort0, miso0, addr0, wdata0}, 64'h0);
    rstb = 1'b1;
    #100;
    cs_n[0] = 1'b1;
    #200;
    a0 = abort_cnt[0];
    exp_q[0].push_back(mk(1'b1, 7'h01, 32'h77));
    frame_start(0, 2'b00);
    xfer(0, 8, 32'h81, rx);
    xfer(0, 8, 32'h77, rx);
    frame_end(0);
    chk("t6_no_abort", abort_cnt[0] - a0, 0);

    // 7: 16-bit word
    exp_q[2].push_back(mk(1'b1, 7'h02, 32'hBEEF));
    frame_start(2, 2'b00);
    xfer(2, 8, 32'h82, rx);
    chk("t7_miso_status", rx, 64'hC3);
    xfer(2, 16, 32'hBEEF, rx);
    frame_end(2);

    repeat (20) @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("pending_events_dut%0d", i), exp_q[i].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
